countdown_time_entry: RTL and testbench
=======================================

// Module: countdown_time_entry
// PURPOSE
// - Operator-side front end for the countdown timer: debounces four push-buttons and edits a 4-digit BCD time.
// - Launches the countdown with a one-cycle start pulse carrying the binary time.
// - Waits for the timer's stop pulse, then blinks an alarm LED before returning to edit.
// - Drives time_in/start of the countdown timer and consumes its stop output.
// PARAMETERS
// - DEBOUNCE_CYCLES  1_000_000   cycles a synchronized button level must be stable to be accepted (10 ms @ 100 MHz)
// - BLINK_DIV        25_000_000  cycles per alarm LED half-period
// - ALARM_BLINKS     6           full on/off alarm periods before auto-return to EDIT
// PORTS
// - clk         in   1   system clock
// - rst_n       in   1   asynchronous, active-low reset
// - btn_up      in   1   raw button: increment selected digit
// - btn_down    in   1   raw button: decrement selected digit
// - btn_sel     in   1   raw button: select next digit
// - btn_go      in   1   raw button: launch countdown
// - stop_in     in   1   one-cycle pulse from the timer when the countdown ends
// - time_out    out  16  binary time = d3*1000 + d2*100 + d1*10 + d0
// - start_out   out  1   one-cycle launch pulse; time_out is stable while it is high
// - busy        out  1   high in LAUNCH, WAIT_STOP and ALARM
// - digits      out  16  BCD {d3,d2,d1,d0}, for the edit display
// - digit_sel   out  2   selected digit index (0 = units)
// - alarm_led   out  1   alarm blink output
// BEHAVIOUR
// - Reset: state=EDIT; digits=0; digit_sel=0; time_out=0; start_out=0; busy=0; alarm_led=0; debounce counters and levels 0.
// - Button input path:
//   - Each button passes through a 2-FF synchronizer, then a debounce counter.
//   - The debounced level updates only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
//   - Any mismatch clears the counter.
//   - The debounced rising edge gives a 1-cycle press event; a held button gives exactly one event.
// - time_out: registered from the digits register, 1-cycle latency, range 0..9999; bits 15:14 always 0.
// - Same-cycle press events: only the highest-priority event acts, go > sel > up > down; the rest are dropped.
// - EDIT:
//   - up: d[digit_sel] +1, 9 wraps to 0, no carry.
//   - down: d[digit_sel] -1, 0 wraps to 9, no borrow.
//   - sel: digit_sel +1, 3 wraps to 0.
//   - go with digits != 0 -> LAUNCH. go with digits == 0 is ignored; state stays EDIT.
//   - stop_in is ignored in EDIT.
// - LAUNCH (1 cycle): start_out=1, busy=1, time_out matches digits -> WAIT_STOP.
// - WAIT_STOP: busy=1; all press events are ignored; stop_in=1 -> ALARM.
// - ALARM:
//   - On entry: alarm_led=1 and the blink counter is cleared.
//   - alarm_led toggles every BLINK_DIV cycles.
//   - After 2*ALARM_BLINKS half-periods: alarm_led=0 -> EDIT.
//   - Any press event aborts: next cycle alarm_led=0, state EDIT; that press is consumed and does not edit.
// - digits and digit_sel are retained across a launch, so the same time can be relaunched.
// - start_out is registered and glitch-free; it is never high outside LAUNCH.
// - rst_n low in any state: immediate async return to reset values; an in-flight stop_in is lost.
// TESTING (DEBOUNCE_CYCLES=4, BLINK_DIV=8, ALARM_BLINKS=2)
// - Debounce:
//   - btn_up toggling every 2 cycles for 40 cycles -> digits stay 16'h0000.
//   - btn_up held 20 cycles -> digits=16'h0001, exactly one increment.
// - Edit and launch:
//   - Enter 0123 via sel/up (d0=3, d1=2, d2=1), then go.
//   - start_out high exactly 1 cycle with time_out=16'd123; then busy=1.
//   - Further button presses do not change digits.
// - Wrap:
//   - down on d0=0 -> d0=9 with d1..d3 unchanged.
//   - up on d3=9 -> d3=0.
//   - sel pressed 4 times -> digit_sel back to 0.
// - Zero / priority:
//   - go with digits=0000 -> no start_out, state stays EDIT.
//   - go and up debounced in the same cycle -> launch occurs, digit unchanged.
// - Alarm:
//   - stop_in pulse in WAIT_STOP -> alarm_led pattern 8 high/8 low x2, then EDIT with busy=0.
//   - Repeat with btn_sel press mid-alarm -> alarm_led=0 and EDIT next cycle, digit_sel unchanged.
// - Reset: assert rst_n low during WAIT_STOP -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/countdown_time_entry.sv
// Operator front end for the countdown timer: debounced buttons edit a 4-digit BCD time,
// launch the timer with a start pulse, then blink an alarm after the timer's stop pulse.
module countdown_time_entry #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_DIV       = 25_000_000,
  parameter int ALARM_BLINKS    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_sel,
  input  logic        btn_go,
  input  logic        stop_in,
  output logic [15:0] time_out,
  output logic        start_out,
  output logic        busy,
  output logic [15:0] digits,
  output logic [1:0]  digit_sel,
  output logic        alarm_led
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BL_W   = $clog2(BLINK_DIV + 1);
  localparam int HALF_W = $clog2(2 * ALARM_BLINKS + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0]   BL_LAST   = BL_W'(BLINK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * ALARM_BLINKS - 1);

  typedef enum logic [1:0] {
    EDIT      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_STOP = 2'd2,
    ALARM     = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Button index order: 0 up, 1 down, 2 sel, 3 go
  logic [3:0]      btn_raw;
  logic [3:0]      btn_p0;
  logic [3:0]      btn_p1;
  logic [3:0]      db_level;
  logic [3:0]      press;
  logic [DB_W-1:0] db_cnt [4];

  logic go_evt, sel_evt, up_evt, down_evt, any_evt;

  logic [BL_W-1:0]   blink_cnt;
  logic [HALF_W-1:0] half_cnt;
  logic              blink_wrap;
  logic              half_last;

  function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic inc);
    logic [3:0] r;
    if (inc) r = (d >= 4'd9) ? 4'd0 : d + 4'd1;
    else     r = (d == 4'd0) ? 4'd9 : d - 4'd1;
    return r;
  endfunction

  function automatic logic [15:0] bcd_to_bin(input logic [15:0] b);
    return ({12'd0, b[15:12]} * 16'd1000) + ({12'd0, b[11:8]} * 16'd100)
         + ({12'd0, b[7:4]} * 16'd10) + {12'd0, b[3:0]};
  endfunction

  assign btn_raw = {btn_go, btn_sel, btn_down, btn_up};

  // Stage p0/p1: two-flop synchronizer; then per-button debounce and rising-edge event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_p0   <= '0;
      btn_p1   <= '0;
      db_level <= '0;
      press    <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      btn_p0 <= btn_raw;
      btn_p1 <= btn_p0;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (btn_p1[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]   <= '0;
          db_level[i] <= btn_p1[i];
          press[i]    <= btn_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Simultaneous events resolve go > sel > up > down; losers are dropped
  assign go_evt   = press[3];
  assign sel_evt  = press[2] & ~press[3];
  assign up_evt   = press[0] & ~press[3] & ~press[2];
  assign down_evt = press[1] & ~press[3] & ~press[2] & ~press[0];
  assign any_evt  = |press;

  assign blink_wrap = (blink_cnt == BL_LAST);
  assign half_last  = (half_cnt == HALF_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EDIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EDIT:      if (go_evt && (digits != 16'h0000)) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_STOP;
      WAIT_STOP: if (stop_in) state_nxt = ALARM;
      ALARM: begin
        if (any_evt)                      state_nxt = EDIT;
        else if (blink_wrap && half_last) state_nxt = EDIT;
      end
      default:   state_nxt = EDIT;
    endcase
  end

  // Digit editing only in EDIT; a go press never edits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits    <= '0;
      digit_sel <= '0;
    end else if (state == EDIT) begin
      if (sel_evt) begin
        digit_sel <= digit_sel + 2'd1;
      end else if (up_evt || down_evt) begin
        digits[{digit_sel, 2'b00} +: 4] <= bcd_step(digits[{digit_sel, 2'b00} +: 4], up_evt);
      end
    end
  end

  // Output registers follow the next state so start_out/busy align with the state itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_out  <= '0;
      start_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      time_out  <= bcd_to_bin(digits);
      start_out <= (state_nxt == LAUNCH);
      busy      <= (state_nxt != EDIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_led <= 1'b0;
      blink_cnt <= '0;
      half_cnt  <= '0;
    end else if (state == WAIT_STOP && state_nxt == ALARM) begin
      alarm_led <= 1'b1;
      blink_cnt <= '0;
      half_cnt  <= '0;
    end else if (state == ALARM) begin
      if (state_nxt == EDIT) begin
        alarm_led <= 1'b0;
      end else if (blink_wrap) begin
        alarm_led <= ~alarm_led;
        blink_cnt <= '0;
        half_cnt  <= half_cnt + 1'b1;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      alarm_led <= 1'b0;
    end
  end

endmodule

// File: tb/tb_countdown_time_entry.sv
// Directed and randomized bench for countdown_time_entry with a digit-level reference model.
module tb_countdown_time_entry;

  localparam int DB = 4;
  localparam int BD = 8;
  localparam int AB = 2;

  localparam logic [3:0] UP   = 4'b0001;
  localparam logic [3:0] DOWN = 4'b0010;
  localparam logic [3:0] SEL  = 4'b0100;
  localparam logic [3:0] GO   = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_up, btn_down, btn_sel, btn_go, stop_in;
  logic [15:0] time_out;
  logic        start_out, busy, alarm_led;
  logic [15:0] digits;
  logic [1:0]  digit_sel;

  int checks = 0;
  int errors = 0;

  int md [4];
  int msel;

  int start_cnt = 0;
  int start_run = 0;
  int max_run   = 0;
  logic [15:0] start_time = '0;

  countdown_time_entry #(
    .DEBOUNCE_CYCLES(DB),
    .BLINK_DIV(BD),
    .ALARM_BLINKS(AB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel), .btn_go(btn_go),
    .stop_in(stop_in),
    .time_out(time_out), .start_out(start_out), .busy(busy),
    .digits(digits), .digit_sel(digit_sel), .alarm_led(alarm_led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_out) begin
      start_cnt++;
      start_time = time_out;
      start_run++;
      if (start_run > max_run) max_run = start_run;
    end else begin
      start_run = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btns(input logic [3:0] m);
    btn_up   = m[0];
    btn_down = m[1];
    btn_sel  = m[2];
    btn_go   = m[3];
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    set_btns(m);
    cyc(hold);
    set_btns(4'b0000);
    cyc(2 + DB + 4);
  endtask

  // Pulses of at most DB-1 cycles must never register
  task automatic glitch(input logic [3:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      set_btns(m);
      cyc(int'($urandom_range(1, DB - 1)));
      set_btns(4'b0000);
      cyc(int'($urandom_range(1, 3)));
    end
    cyc(DB + 2);
  endtask

  function automatic logic [15:0] model_digits();
    return 16'(md[3] * 4096 + md[2] * 256 + md[1] * 16 + md[0]);
  endfunction

  function automatic logic [15:0] model_time();
    return 16'(md[3] * 1000 + md[2] * 100 + md[1] * 10 + md[0]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) md[i] = 0;
    msel = 0;
  endtask

  task automatic model_edit(input logic [3:0] m);
    if (m[3]) return;
    if (m[2])      msel = (msel + 1) % 4;
    else if (m[0]) md[msel] = (md[msel] + 1) % 10;
    else if (m[1]) md[msel] = (md[msel] + 9) % 10;
  endtask

  task automatic edit_press(input logic [3:0] m);
    press(m, int'($urandom_range(DB + 1, DB + 8)));
    model_edit(m);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_digits"}, 32'(digits), 32'(model_digits()));
    check({tag, "_sel"}, 32'(digit_sel), 32'(msel));
    check({tag, "_time"}, 32'(time_out), 32'(model_time()));
  endtask

  task automatic launch(input string tag);
    int c0;
    c0 = start_cnt;
    max_run = 0;
    press(GO, DB + 4);
    check({tag, "_starts"}, 32'(start_cnt), 32'(c0 + 1));
    check({tag, "_start_width"}, 32'(max_run), 32'd1);
    check({tag, "_start_time"}, 32'(start_time), 32'(model_time()));
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic stop_pulse();
    stop_in = 1'b1;
    cyc(1);
    stop_in = 1'b0;
  endtask

  initial begin
    logic [31:0] led_obs, led_exp;
    int c0;
    logic [3:0] m;

    rst_n = 1'b0;
    stop_in = 1'b0;
    set_btns(4'b0000);
    model_reset();
    cyc(3);
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_sel", 32'(digit_sel), 32'h0);
    check("rst_time", 32'(time_out), 32'h0);
    check("rst_start", 32'(start_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_led", 32'(alarm_led), 32'h0);
    rst_n = 1'b1;
    cyc(2);

    // Bouncing button: toggles every 2 cycles for 40 cycles
    for (int k = 0; k < 20; k++) begin
      btn_up = ~btn_up;
      cyc(2);
    end
    btn_up = 1'b0;
    cyc(10);
    check("bounce_digits", 32'(digits), 32'h0);

    press(UP, 20);
    model_edit(UP);
    check("held_up", 32'(digits), 32'h0001);

    edit_press(DOWN);
    edit_press(DOWN);
    check("d0_wrap_down", 32'(digits), 32'h0009);
    check_model("wrap_down");

    edit_press(SEL); edit_press(SEL); edit_press(SEL);
    edit_press(DOWN);
    check("d3_down", 32'(digits), 32'h9009);
    edit_press(UP);
    check("d3_wrap_up", 32'(digits), 32'h0009);
    edit_press(SEL);
    check("sel_wrap", 32'(digit_sel), 32'd0);

    // Enter 0123
    for (int k = 0; k < 4; k++) edit_press(UP);
    edit_press(SEL); edit_press(UP); edit_press(UP);
    edit_press(SEL); edit_press(UP);
    edit_press(SEL); edit_press(SEL);
    check("entry_0123", 32'(digits), 32'h0123);
    check_model("entry");

    launch("go123");
    check("go123_time_lit", 32'(start_time), 32'd123);

    c0 = start_cnt;
    press(UP, DB + 3); press(SEL, DB + 3); press(GO, DB + 3); press(DOWN, DB + 3);
    check("wait_digits", 32'(digits), 32'h0123);
    check("wait_sel", 32'(digit_sel), 32'd0);
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_nostart", 32'(start_cnt), 32'(c0));

    // Full alarm: BD high / BD low, AB times
    stop_pulse();
    led_obs = '0;
    led_exp = '0;
    for (int k = 0; k < 2 * AB * BD; k++) begin
      led_obs[k] = alarm_led;
      led_exp[k] = ((k / BD) % 2) == 0;
      cyc(1);
    end
    check("alarm_pattern", led_obs, led_exp);
    check("alarm_end_led", 32'(alarm_led), 32'd0);
    check("alarm_end_busy", 32'(busy), 32'd0);
    check_model("after_alarm");

    // Relaunch same time, then abort alarm with sel
    launch("relaunch");
    set_btns(SEL);
    stop_pulse();
    check("abort_alarm_on", 32'(alarm_led), 32'd1);
    cyc(6);
    check("abort_led", 32'(alarm_led), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    cyc(2);
    set_btns(4'b0000);
    cyc(10);
    check_model("abort");

    // go and up in the same cycle: launch wins, digit untouched
    press(GO | UP, DB + 4);
    check("prio_busy", 32'(busy), 32'd1);
    check("prio_digits", 32'(digits), 32'(model_digits()));

    // Async reset during WAIT_STOP
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_digits", 32'(digits), 32'h0);
    check("arst_sel", 32'(digit_sel), 32'h0);
    check("arst_time", 32'(time_out), 32'h0);
    check("arst_start", 32'(start_out), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_led", 32'(alarm_led), 32'h0);
    model_reset();
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    c0 = start_cnt;
    press(GO, DB + 4);
    check("zero_go_nostart", 32'(start_cnt), 32'(c0));
    check("zero_go_busy", 32'(busy), 32'd0);

    // Randomized editing with interleaved glitches
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 2))
        0:       m = UP;
        1:       m = DOWN;
        default: m = SEL;
      endcase
      glitch(4'(1 << $urandom_range(0, 3)), int'($urandom_range(0, 3)));
      edit_press(m);
      check_model("rand");
    end

    if (model_digits() != 16'h0000) begin
      launch("rand_go");
      stop_pulse();
      cyc(2 * AB * BD + 2);
      check("rand_alarm_done", 32'(busy), 32'd0);
    end else begin
      c0 = start_cnt;
      press(GO, DB + 4);
      check("rand_zero_go", 32'(start_cnt), 32'(c0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
